// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding uart_tx with a level-held valid/byte pair.
// Optional UART_TX_FIFO_LEVEL_EN adds o_Level and o_AlmostFull outputs.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_SysClock,
  input  logic                  i_Reset,
  input  logic                  i_WrValid,
  input  logic [DATA_WIDTH-1:0] i_WrByte,
  output logic                  o_WrReady,
  output logic                  o_Overflow,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_TxValid,
  output logic [DATA_WIDTH-1:0] o_TxByte,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [DEPTH_LOG2:0]   o_Level,
  output logic                  o_AlmostFull,
`endif
  input  logic                  i_TxDone
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT =
    (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } txState_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   count;
  txState_t              state;
  txState_t              stateNext;
  logic                  wrFire;
  logic                  popFire;

  // Flags come straight from the occupancy count.
  assign o_Full    = (count == DEPTH_CNT);
  assign o_Empty   = (count == '0);
  assign o_WrReady = ~o_Full;
  assign wrFire    = i_WrValid & o_WrReady;

`ifdef UART_TX_FIFO_LEVEL_EN
  localparam logic [DEPTH_LOG2:0] ALMOST_CNT =
    DEPTH_CNT - (DEPTH_LOG2 + 1)'(2);

  assign o_Level      = count;
  assign o_AlmostFull = (count >= ALMOST_CNT);
`endif

  // Next-state logic: pop only when leaving IDLE with data queued.
  always_comb begin
    stateNext = state;
    popFire   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          popFire   = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (i_TxDone) begin
          stateNext = GAP;
        end
      end
      GAP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register and the held byte/valid toward uart_tx.
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state     <= IDLE;
      o_TxValid <= 1'b0;
      o_TxByte  <= '0;
    end else begin
      state     <= stateNext;
      o_TxValid <= (stateNext == SEND);
      if (popFire) begin
        o_TxByte <= mem[rdPtr];
      end
    end
  end

  // Storage array; stale contents are harmless once count is cleared.
  always_ff @(posedge i_SysClock) begin
    if (wrFire) begin
      mem[wrPtr] <= i_WrByte;
    end
  end

  // Pointers, occupancy and the dropped-write pulse.
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      o_Overflow <= i_WrValid & o_Full;
      if (wrFire) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popFire) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({wrFire, popFire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with a queue-based reference model
// and a behavioural uart_tx responder generating i_TxDone.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrValid;
  logic [7:0] wrByte;
  logic       wrReady;
  logic       overflow;
  logic       full;
  logic       empty;
  logic       txValid;
  logic [7:0] txByte;
  logic       txDone;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
  logic       almostFull;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH_LOG2(4)
  ) dut (
    .i_SysClock  (clk),
    .i_Reset     (rst),
    .i_WrValid   (wrValid),
    .i_WrByte    (wrByte),
    .o_WrReady   (wrReady),
    .o_Overflow  (overflow),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_TxValid   (txValid),
    .o_TxByte    (txByte),
`ifdef UART_TX_FIFO_LEVEL_EN
    .o_Level     (level),
    .o_AlmostFull(almostFull),
`endif
    .i_TxDone    (txDone)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mdlQ[$];
  logic [7:0] sb[$];
  bit mdlSend = 0;
  int mdlGap = 0;
  bit mdlOvf = 0;
  int sendAge = 0;
  bit stall = 0;
  bit spur = 0;
  int doneDelay = 3;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: a queue of stored bytes plus a transmitter that is
  // either busy, cooling down one cycle, or free to take the head.
  task automatic modelEdge(bit wv, logic [7:0] wb, bit dn, bit rs);
    bit wasFull;
    int pre;
    if (rs) begin
      mdlQ.delete();
      sb.delete();
      mdlSend = 0;
      mdlGap = 0;
      mdlOvf = 0;
      sendAge = 0;
      return;
    end
    pre = mdlQ.size();
    wasFull = (pre == 16);
    mdlOvf = wv && wasFull;
    if (mdlSend) begin
      if (dn) begin
        mdlSend = 0;
        mdlGap = 1;
      end else begin
        sendAge++;
      end
    end else if (mdlGap > 0) begin
      mdlGap = 0;
    end else if (pre > 0) begin
      sb.push_back(mdlQ.pop_front());
      mdlSend = 1;
      sendAge = 0;
    end
    if (wv && !wasFull) mdlQ.push_back(wb);
  endtask

  function automatic bit genDone();
    if (mdlSend && !stall && sendAge >= doneDelay) begin
      doneDelay = $urandom_range(0, 6);
      return 1'b1;
    end
    if (!mdlSend && spur && $urandom_range(0, 3) == 0)
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(bit wv, logic [7:0] wb, bit dn, bit rs);
    wrValid = wv;
    wrByte = wb;
    txDone = dn;
    rst = rs;
    @(posedge clk);
    modelEdge(wv, wb, dn, rs);
    #1;
    check("txValid", txValid, mdlSend);
    check("full", full, mdlQ.size() == 16);
    check("empty", empty, mdlQ.size() == 0);
    check("wrReady", wrReady, mdlQ.size() != 16);
    check("overflow", overflow, mdlOvf);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level", level, mdlQ.size());
    check("almostFull", almostFull, mdlQ.size() >= 14);
`endif
  endtask

  task automatic wr(logic [7:0] b);
    step(1'b1, b, genDone(), 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, genDone(), 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mdlQ.size() > 0 || mdlSend || mdlGap > 0) && n < 2000) begin
      idle();
      n++;
    end
    check("drainTimeout", n < 2000, 1'b1);
  endtask

  // Monitor: every new transmission must carry the oldest expected byte
  // and hold it steady until valid drops.
  initial begin
    logic prevV;
    logic [7:0] held;
    prevV = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (txValid === 1'b1 && prevV !== 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL txByteOrder: got %0h expected none at %0t",
                   txByte, $time);
        end else begin
          check("txByteOrder", txByte, sb.pop_front());
        end
        held = txByte;
      end else if (txValid === 1'b1) begin
        check("txByteHold", txByte, held);
      end
      prevV = txValid;
    end
  end

  initial begin
    wrValid = 1'b0;
    wrByte = 8'h00;
    txDone = 1'b0;
    rst = 1'b1;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("txByteRst", txByte, 8'h00);

    wr(8'hA5);
    drain();

    wr(8'hFF);
    wr(8'h00);
    wr(8'h55);
    wr(8'hAA);
    drain();

    stall = 1;
    for (int i = 0; i < 17; i++) wr(8'(i));
    check("fullAfter17", full, 1'b1);
    wr(8'h11);
    idle();
    stall = 0;
    drain();

    stall = 1;
    for (int i = 0; i < 17; i++) wr(8'(8'h20 + i));
    stall = 0;
    for (int i = 0; i < 8; i++) wr(8'(8'h40 + i));
    drain();

    stall = 1;
    for (int i = 0; i < 6; i++) wr(8'(8'h50 + i));
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rstValid", txValid, 1'b0);
    check("rstEmpty", empty, 1'b1);
    stall = 0;
    idle();
    wr(8'h3C);
    drain();

    stall = 1;
    for (int i = 0; i < 15; i++) wr(8'(8'h60 + i));
    stall = 0;
    drain();

    spur = 1;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 499) == 0)
        step(1'b0, 8'h00, 1'b0, 1'b1);
      else
        step($urandom_range(0, 2) != 0, 8'($urandom),
             genDone(), 1'b0);
    end
    stall = 0;
    spur = 0;
    drain();
    repeat (2) idle();
    check("sbEmpty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
